// File: rtl/ara_runtime_monitor.sv
// Runtime/stall performance monitor for Ara with an APB read port.
// Counters snapshot into buffers when Ara drains after the last dispatched vector instruction.
module ara_runtime_monitor #(
    parameter int unsigned CntWidth  = 64,
    parameter int unsigned AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cnt_en_i,
    input  logic                 acc_req_valid_i,
    input  logic                 ara_idle_i,
    input  logic                 dcache_miss_i,
    input  logic                 icache_miss_i,
    input  logic                 sb_full_i,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic [31:0]          pwdata_i,
    output logic [31:0]          prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    output logic [CntWidth-1:0]  runtime_o,
    output logic                 snap_valid_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CntWidth-1:0] CNT_MAX = '1;
    localparam logic [CntWidth-1:0] CNT_ONE = CntWidth'(1);

    state_t              r_state, w_state_nxt;
    logic                r_pending, r_ovf, r_snap_valid;
    logic [31:0]         r_snap_count, r_shadow;
    logic [CntWidth-1:0] r_runtime_cnt, r_dc_cnt, r_ic_cnt, r_sb_cnt;
    logic [CntWidth-1:0] r_buf_rt, r_buf_dc, r_buf_ic, r_buf_sb;
    logic [CntWidth-1:0] w_rt_nxt, w_dc_nxt, w_ic_nxt, w_sb_nxt;

    logic       w_active, w_rt_inc, w_dc_inc, w_ic_inc, w_sb_inc, w_sat;
    logic       w_snap, w_acc, w_err, w_rd, w_clear, w_is_lo;
    logic [5:0] w_addr;
    logic [31:0] w_rdata, w_hi_lat;
    logic       w_unused;

    assign w_unused = ^{paddr_i[AddrWidth-1:6], pwdata_i[31:1]};

    // APB decode
    assign w_addr    = paddr_i[5:0];
    assign w_acc     = psel_i & penable_i;
    assign w_err     = w_acc & ((w_addr[1:0] != 2'b00) | (w_addr > 6'h24) |
                                (pwrite_i & (w_addr != 6'h00)));
    assign w_rd      = w_acc & ~pwrite_i & ~w_err;
    assign w_clear   = w_acc & pwrite_i & ~w_err & pwdata_i[0];
    assign pready_o  = 1'b1;
    assign pslverr_o = w_err;

    // FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (acc_req_valid_i & cnt_en_i) w_state_nxt = ST_RUN;
            ST_RUN:   if (!cnt_en_i) w_state_nxt = ara_idle_i ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (cnt_en_i)        w_state_nxt = ST_RUN;
                else if (ara_idle_i) w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Saturating counters
    assign w_active = (r_state == ST_RUN) | (r_state == ST_DRAIN);
    assign w_rt_inc = w_active;
    assign w_dc_inc = w_active & dcache_miss_i;
    assign w_ic_inc = w_active & icache_miss_i;
    assign w_sb_inc = w_active & sb_full_i;

    assign w_rt_nxt = (w_rt_inc && r_runtime_cnt != CNT_MAX) ? r_runtime_cnt + CNT_ONE : r_runtime_cnt;
    assign w_dc_nxt = (w_dc_inc && r_dc_cnt != CNT_MAX) ? r_dc_cnt + CNT_ONE : r_dc_cnt;
    assign w_ic_nxt = (w_ic_inc && r_ic_cnt != CNT_MAX) ? r_ic_cnt + CNT_ONE : r_ic_cnt;
    assign w_sb_nxt = (w_sb_inc && r_sb_cnt != CNT_MAX) ? r_sb_cnt + CNT_ONE : r_sb_cnt;
    assign w_sat    = (w_rt_inc & (r_runtime_cnt == CNT_MAX)) | (w_dc_inc & (r_dc_cnt == CNT_MAX)) |
                      (w_ic_inc & (r_ic_cnt == CNT_MAX)) | (w_sb_inc & (r_sb_cnt == CNT_MAX));

    assign w_snap = r_pending & ara_idle_i & ~acc_req_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_runtime_cnt <= '0;
            r_dc_cnt      <= '0;
            r_ic_cnt      <= '0;
            r_sb_cnt      <= '0;
            r_ovf         <= 1'b0;
        end else if (w_clear) begin
            r_runtime_cnt <= '0;
            r_dc_cnt      <= '0;
            r_ic_cnt      <= '0;
            r_sb_cnt      <= '0;
            r_ovf         <= 1'b0;
        end else begin
            r_runtime_cnt <= w_rt_nxt;
            r_dc_cnt      <= w_dc_nxt;
            r_ic_cnt      <= w_ic_nxt;
            r_sb_cnt      <= w_sb_nxt;
            if (w_sat) r_ovf <= 1'b1;
        end
    end

    // Buffers capture the count including the drain cycle itself
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_buf_rt     <= '0;
            r_buf_dc     <= '0;
            r_buf_ic     <= '0;
            r_buf_sb     <= '0;
            r_snap_count <= '0;
        end else if (w_clear) begin
            r_buf_rt     <= '0;
            r_buf_dc     <= '0;
            r_buf_ic     <= '0;
            r_buf_sb     <= '0;
            r_snap_count <= '0;
        end else if (w_snap) begin
            r_buf_rt     <= w_rt_nxt;
            r_buf_dc     <= w_dc_nxt;
            r_buf_ic     <= w_ic_nxt;
            r_buf_sb     <= w_sb_nxt;
            r_snap_count <= r_snap_count + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending    <= 1'b0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= w_snap & ~w_clear;
            if (w_snap)               r_pending <= 1'b0;
            else if (acc_req_valid_i) r_pending <= 1'b1;
        end
    end

    // Register read mux; lo reads also name the hi word to park in the shadow
    always_comb begin
        w_rdata  = '0;
        w_hi_lat = '0;
        w_is_lo  = 1'b0;
        case (w_addr)
            6'h00: w_rdata = {27'd0, r_ovf, r_state, r_pending, 1'b0};
            6'h04: w_rdata = r_snap_count;
            6'h08: begin w_rdata = r_buf_rt[31:0]; w_hi_lat = r_buf_rt[CntWidth-1:32]; w_is_lo = 1'b1; end
            6'h10: begin w_rdata = r_buf_dc[31:0]; w_hi_lat = r_buf_dc[CntWidth-1:32]; w_is_lo = 1'b1; end
            6'h18: begin w_rdata = r_buf_ic[31:0]; w_hi_lat = r_buf_ic[CntWidth-1:32]; w_is_lo = 1'b1; end
            6'h20: begin w_rdata = r_buf_sb[31:0]; w_hi_lat = r_buf_sb[CntWidth-1:32]; w_is_lo = 1'b1; end
            6'h0C, 6'h14, 6'h1C, 6'h24: w_rdata = r_shadow;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                r_shadow <= '0;
        else if (w_rd & w_is_lo)  r_shadow <= w_hi_lat;
    end

    assign prdata_o     = w_rd ? w_rdata : 32'd0;
    assign runtime_o    = r_buf_rt;
    assign snap_valid_o = r_snap_valid;

endmodule

// File: tb/tb_ara_runtime_monitor.sv
// Directed bench for ara_runtime_monitor: runtime/stall snapshots, drain, saturation, shadow reads, errors, reset.
module tb_ara_runtime_monitor;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cnt_en = 1'b0, acc = 1'b0, idle = 1'b1, dc = 1'b0, ic = 1'b0, sb = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o, snap_valid_o;
    logic [63:0] runtime_o;

    int n_vec = 0, n_err = 0, n_pulse = 0;
    logic [31:0] rd;
    logic        er;

    ara_runtime_monitor dut (
        .clk_i(clk), .rst_i(rst), .cnt_en_i(cnt_en), .acc_req_valid_i(acc), .ara_idle_i(idle),
        .dcache_miss_i(dc), .icache_miss_i(ic), .sb_full_i(sb),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .runtime_o(runtime_o), .snap_valid_o(snap_valid_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (snap_valid_o) n_pulse++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apb(input logic wr, input logic [5:0] a, input logic [31:0] wd,
                       output logic [31:0] d, output logic e);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = {26'd0, a}; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata_o; e = pslverr_o;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        apb(1'b0, a, 32'd0, rd, er);
        chk({tag, ".data"}, {32'd0, rd}, {32'd0, exp});
        chk({tag, ".err"}, {63'd0, er}, 64'd0);
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        // reset state
        chk("rst.runtime", runtime_o, 64'd0);
        chk("rst.snapv", {63'd0, snap_valid_o}, 64'd0);
        chk("rst.prdata", {32'd0, prdata_o}, 64'd0);
        chk("rst.pready", {63'd0, pready_o}, 64'd1);
        rd_chk("rst.status", 6'h00, 32'h0);
        rd_chk("rst.snapcnt", 6'h04, 32'h0);

        // 100-cycle vector window with dcache/sb stalls
        cnt_en = 1'b1; idle = 1'b1; tick(5);
        n_pulse = 0;
        acc = 1'b1; idle = 1'b0; tick(1);
        acc = 1'b0;
        for (int i = 0; i < 99; i++) begin
            dc = (i >= 20 && i < 27);
            sb = (i >= 40 && i < 43);
            tick(1);
        end
        dc = 1'b0; sb = 1'b0; idle = 1'b1; tick(1);
        chk("w1.snapv_hi", {63'd0, snap_valid_o}, 64'd1);
        chk("w1.runtime", runtime_o, 64'd100);
        tick(1);
        chk("w1.snapv_lo", {63'd0, snap_valid_o}, 64'd0);
        cnt_en = 1'b0; tick(1);
        chk("w1.pulses", 64'(n_pulse), 64'd1);
        rd_chk("w1.snapcnt", 6'h04, 32'd1);
        rd_chk("w1.rt_lo", 6'h08, 32'd100);
        rd_chk("w1.rt_hi", 6'h0C, 32'd0);
        rd_chk("w1.dc_lo", 6'h10, 32'd7);
        rd_chk("w1.dc_hi", 6'h14, 32'd0);
        rd_chk("w1.sb_lo", 6'h20, 32'd3);
        rd_chk("w1.sb_hi", 6'h24, 32'd0);
        rd_chk("w1.status", 6'h00, 32'h0);

        // drain: cnt_en drops while Ara busy, idle 20 cycles later
        apb(1'b1, 6'h00, 32'd1, rd, er);
        chk("clr1.err", {63'd0, er}, 64'd0);
        rd_chk("clr1.snapcnt", 6'h04, 32'd0);
        cnt_en = 1'b1; acc = 1'b1; idle = 1'b0; tick(1);
        acc = 1'b0; ic = 1'b1; tick(2);
        ic = 1'b0; tick(8);
        cnt_en = 1'b0; tick(1);
        rd_chk("dr.status", 6'h00, 32'hA);
        tick(17);
        idle = 1'b1; tick(1);
        chk("dr.runtime", runtime_o, 64'd31);
        rd_chk("dr.status_idle", 6'h00, 32'h0);
        rd_chk("dr.ic_lo", 6'h18, 32'd2);

        // dispatch coinciding with idle holds off the snapshot
        n_pulse = 0;
        cnt_en = 1'b1; acc = 1'b1; tick(2);
        chk("co.snapv", {63'd0, snap_valid_o}, 64'd0);
        acc = 1'b0; tick(1);
        chk("co.snapv_hi", {63'd0, snap_valid_o}, 64'd1);
        cnt_en = 1'b0; tick(1);
        chk("co.pulses", 64'(n_pulse), 64'd1);

        // saturation and CLEAR
        cnt_en = 1'b1; acc = 1'b1; idle = 1'b0; tick(1);
        acc = 1'b0;
        force dut.r_runtime_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        #1 release dut.r_runtime_cnt;
        tick(5);
        idle = 1'b1; tick(1);
        chk("sat.runtime", runtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
        cnt_en = 1'b0; tick(1);
        rd_chk("sat.status", 6'h00, 32'h10);
        rd_chk("sat.snapcnt", 6'h04, 32'd3);
        apb(1'b1, 6'h00, 32'd1, rd, er);
        rd_chk("clr2.status", 6'h00, 32'h0);
        rd_chk("clr2.snapcnt", 6'h04, 32'd0);
        rd_chk("clr2.rt_lo", 6'h08, 32'd0);
        chk("clr2.runtime", runtime_o, 64'd0);

        // tear-free hi reads through the shadow
        cnt_en = 1'b1; acc = 1'b1; idle = 1'b0; tick(1);
        acc = 1'b0;
        force dut.r_runtime_cnt = 64'h1_0000_0000;
        #1 release dut.r_runtime_cnt;
        tick(4);
        idle = 1'b1; tick(1);
        chk("tf.runtime1", runtime_o, 64'h1_0000_0005);
        rd_chk("tf.lo1", 6'h08, 32'd5);
        acc = 1'b1; idle = 1'b0; tick(1);
        acc = 1'b0;
        force dut.r_runtime_cnt = 64'h2_0000_0000;
        #1 release dut.r_runtime_cnt;
        tick(2);
        idle = 1'b1; tick(1);
        chk("tf.runtime2", runtime_o, 64'h2_0000_0003);
        rd_chk("tf.hi_shadow", 6'h0C, 32'd1);
        rd_chk("tf.lo2", 6'h08, 32'd3);
        rd_chk("tf.hi2", 6'h0C, 32'd2);

        // bus errors leave state untouched
        apb(1'b0, 6'h28, 32'd0, rd, er);
        chk("er28.err", {63'd0, er}, 64'd1);
        chk("er28.data", {32'd0, rd}, 64'd0);
        apb(1'b0, 6'h06, 32'd0, rd, er);
        chk("er06.err", {63'd0, er}, 64'd1);
        chk("er06.data", {32'd0, rd}, 64'd0);
        apb(1'b1, 6'h08, 32'hDEAD_BEEF, rd, er);
        chk("erw08.err", {63'd0, er}, 64'd1);
        rd_chk("er.rt_lo", 6'h08, 32'd3);
        rd_chk("er.status", 6'h00, 32'h4);

        // reset in the middle of a run, during a status read
        acc = 1'b1; idle = 1'b0; tick(1);
        acc = 1'b0; tick(5);
        psel = 1'b1; pwrite = 1'b0; paddr = 32'h0;
        @(negedge clk);
        penable = 1'b1;
        #1 chk("mr.status", {32'd0, prdata_o}, 64'h6);
        rst = 1'b1;
        #1;
        chk("mr.prdata", {32'd0, prdata_o}, 64'd0);
        chk("mr.runtime", runtime_o, 64'd0);
        chk("mr.snapv", {63'd0, snap_valid_o}, 64'd0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; rst = 1'b0; cnt_en = 1'b0; idle = 1'b1;
        tick(1);
        rd_chk("mr.status_after", 6'h00, 32'h0);
        rd_chk("mr.snapcnt", 6'h04, 32'd0);
        rd_chk("mr.shadow", 6'h0C, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
